// File: rtl/fb_pkg.sv
// Shared encodings and default frame geometry for the fill engine and the VGA scan-out block.
package fb_pkg;

   localparam int unsigned FB_H_RES   = 160;
   localparam int unsigned FB_V_RES   = 120;
   localparam int unsigned FB_COLOR_W = 16;
   localparam int unsigned FB_ADDR_W  = 16;

   typedef enum logic [1:0] {
      MODE_SOLID   = 2'd0,
      MODE_BORDER  = 2'd1,
      MODE_CHECKER = 2'd2,
      MODE_STRIPES = 2'd3
   } fb_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_wr_if.sv
// Frame RAM write port: one write per cycle when we & mem_ready.
interface fb_wr_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned COLOR_W = 16
);
   logic               we;
   logic [ADDR_W-1:0]  addr;
   logic [COLOR_W-1:0] pixel_color;
   logic               mem_ready;

   modport master (output we, output addr, output pixel_color, input mem_ready);
   modport slave  (input we, input addr, input pixel_color, output mem_ready);
endinterface

// File: rtl/fb_pattern_sel.sv
// Combinational pattern generator: pixel coordinate and mode to colour.
module fb_pattern_sel
   import fb_pkg::*;
#(
   parameter int unsigned H_RES     = FB_H_RES,
   parameter int unsigned V_RES     = FB_V_RES,
   parameter int unsigned COLOR_W   = FB_COLOR_W,
   parameter int unsigned BORDER_W  = 2,
   parameter int unsigned TILE_LOG2 = 3,
   parameter int unsigned XW        = $clog2(H_RES),
   parameter int unsigned YW        = $clog2(V_RES)
)(
   input  logic [XW-1:0]      x,
   input  logic [YW-1:0]      y,
   input  fb_mode_e           mode,
   input  logic [COLOR_W-1:0] fg,
   input  logic [COLOR_W-1:0] bg,
   output logic [COLOR_W-1:0] color_c
);

   logic in_border;
   logic x_tile;
   logic y_tile;
   logic use_fg;

   // Tile bits are taken from zero-extended coordinates so small frames stay legal.
   assign x_tile = 1'((32'(x) >> TILE_LOG2) & 32'd1);
   assign y_tile = 1'((32'(y) >> TILE_LOG2) & 32'd1);

   assign in_border = (32'(x) < BORDER_W) || (32'(x) >= H_RES - BORDER_W) ||
                      (32'(y) < BORDER_W) || (32'(y) >= V_RES - BORDER_W);

   always_comb begin
      use_fg = 1'b1;
      case (mode)
         MODE_SOLID:   use_fg = 1'b1;
         MODE_BORDER:  use_fg = in_border;
         MODE_CHECKER: use_fg = x_tile ^ y_tile;
         MODE_STRIPES: use_fg = y_tile;
         default:      use_fg = 1'b1;
      endcase
   end

   assign color_c = use_fg ? fg : bg;

endmodule

// File: rtl/fb_fill_gen.sv
// Framebuffer fill engine: walks the frame in raster order issuing one RAM write per pixel.
module fb_fill_gen
   import fb_pkg::*;
#(
   parameter int unsigned H_RES     = FB_H_RES,
   parameter int unsigned V_RES     = FB_V_RES,
   parameter int unsigned ADDR_W    = FB_ADDR_W,
   parameter int unsigned COLOR_W   = FB_COLOR_W,
   parameter int unsigned BORDER_W  = 2,
   parameter int unsigned TILE_LOG2 = 3
)(
   input  logic               clk_2M,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [COLOR_W-1:0] fg_color,
   input  logic [COLOR_W-1:0] bg_color,
   fb_wr_if.master            wr,
   output logic               busy,
   output logic               done
);

   localparam int unsigned XW = $clog2(H_RES);
   localparam int unsigned YW = $clog2(V_RES);

   fb_state_e          state;
   logic [XW-1:0]      x;
   logic [YW-1:0]      y;
   fb_mode_e           mode_q;
   logic [COLOR_W-1:0] fg_q;
   logic [COLOR_W-1:0] bg_q;

   logic               accept;
   logic               x_last;
   logic               y_last;
   logic [XW-1:0]      nx;
   logic [YW-1:0]      ny;
   fb_mode_e           sel_mode;
   logic [COLOR_W-1:0] sel_fg;
   logic [COLOR_W-1:0] sel_bg;
   logic [COLOR_W-1:0] pat_c;

   assign accept = wr.we & wr.mem_ready;
   assign x_last = (x == XW'(H_RES - 1));
   assign y_last = (y == YW'(V_RES - 1));

   // Next coordinate and colour source; in IDLE the first pixel uses the live inputs being latched.
   always_comb begin
      nx       = '0;
      ny       = '0;
      sel_mode = mode_q;
      sel_fg   = fg_q;
      sel_bg   = bg_q;
      if (state == ST_IDLE) begin
         sel_mode = fb_mode_e'(mode);
         sel_fg   = fg_color;
         sel_bg   = bg_color;
      end else if (x_last) begin
         ny = y + YW'(1);
      end else begin
         nx = x + XW'(1);
         ny = y;
      end
   end

   fb_pattern_sel #(
      .H_RES     (H_RES),
      .V_RES     (V_RES),
      .COLOR_W   (COLOR_W),
      .BORDER_W  (BORDER_W),
      .TILE_LOG2 (TILE_LOG2),
      .XW        (XW),
      .YW        (YW)
   ) u_pattern (
      .x       (nx),
      .y       (ny),
      .mode    (sel_mode),
      .fg      (sel_fg),
      .bg      (sel_bg),
      .color_c (pat_c)
   );

   always_ff @(posedge clk_2M) begin
      if (rst) begin
         state          <= ST_IDLE;
         x              <= '0;
         y              <= '0;
         mode_q         <= MODE_SOLID;
         fg_q           <= '0;
         bg_q           <= '0;
         wr.we          <= 1'b0;
         wr.addr        <= '0;
         wr.pixel_color <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mode_q         <= fb_mode_e'(mode);
                  fg_q           <= fg_color;
                  bg_q           <= bg_color;
                  x              <= '0;
                  y              <= '0;
                  wr.addr        <= '0;
                  wr.pixel_color <= pat_c;
                  wr.we          <= 1'b1;
                  busy           <= 1'b1;
                  state          <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (accept) begin
                  if (x_last && y_last) begin
                     wr.we <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     x              <= nx;
                     y              <= ny;
                     wr.addr        <= wr.addr + ADDR_W'(1);
                     wr.pixel_color <= pat_c;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               wr.we <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
